// File: rtl/mems_arb_pkg.sv
// Shared types and constants for the MEMS DAC SPI arbiter: owner/state
// encodings, the default VREF setup word and the grant-priority helper.
package mems_arb_pkg;

  localparam int WORD_W = 24;
  localparam logic [WORD_W-1:0] VREF_WORD_DEFAULT = 24'h700000;

  typedef enum logic [1:0] {
    OWN_NONE    = 2'd0,
    OWN_SCAN    = 2'd1,
    OWN_HOST    = 2'd2,
    OWN_REFRESH = 2'd3
  } owner_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_ACCEPT,
    ST_XFER
  } state_e;

  // Refresh always wins; a scan/host tie goes to whoever was not served last.
  function automatic owner_e pick_owner(input logic refresh, input logic scan,
                                        input logic host, input logic last_host);
    if (refresh)      return OWN_REFRESH;
    if (scan && host) return last_host ? OWN_SCAN : OWN_HOST;
    if (scan)         return OWN_SCAN;
    if (host)         return OWN_HOST;
    return OWN_NONE;
  endfunction

endpackage

// File: rtl/mems_spi_arbiter_if.sv
// Requester / SPI-master side signals of the arbiter. The arbiter uses the
// slave modport; the requesters and SPI master sit on the master modport.
interface mems_spi_arbiter_if;
  import mems_arb_pkg::*;

  logic              hold;
  logic              scan_req;
  logic [WORD_W-1:0] scan_word;
  logic              scan_ack;
  logic              host_req;
  logic [WORD_W-1:0] host_word;
  logic              host_ack;
  logic              mems_SPI_busy;
  logic              mems_SPI_start;
  logic [WORD_W-1:0] spi_data;
  logic [1:0]        owner;
  logic              err_clr;
  logic              err_timeout;

  modport master (
    output hold, scan_req, scan_word, host_req, host_word, mems_SPI_busy, err_clr,
    input  scan_ack, host_ack, mems_SPI_start, spi_data, owner, err_timeout
  );

  modport slave (
    input  hold, scan_req, scan_word, host_req, host_word, mems_SPI_busy, err_clr,
    output scan_ack, host_ack, mems_SPI_start, spi_data, owner, err_timeout
  );

endinterface

// File: rtl/mems_refresh_timer.sv
// Free-running VREF refresh timer: raises a sticky pending flag every
// REFRESH_CYCLES clocks, cleared when the arbiter grants the refresh.
module mems_refresh_timer #(
  parameter int REFRESH_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic grant,
  output logic pending
);

  localparam int CW = (REFRESH_CYCLES > 2) ? $clog2(REFRESH_CYCLES) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(REFRESH_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          pending_q, pending_d;
  logic          terminal;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    terminal  = (cnt_q == '0);
    cnt_d     = terminal ? RELOAD : cnt_q - CW'(1);
    pending_d = pending_q;
    if (grant)    pending_d = 1'b0;
    // A terminal count in the grant cycle raises a fresh request.
    if (terminal) pending_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= RELOAD;
      pending_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
    end
  end

  assign pending = pending_q;

endmodule

// File: rtl/mems_spi_arbiter.sv
// Grants the shared MEMS DAC SPI master to scan, host or VREF refresh, one
// 24-bit word at a time. Refresh requester present only with MEMS_ARB_REFRESH_EN.
module mems_spi_arbiter
  import mems_arb_pkg::*;
#(
  parameter int                REFRESH_CYCLES = 50000,
  parameter int                ACCEPT_TIMEOUT = 8,
  parameter logic [WORD_W-1:0] VREF_WORD      = VREF_WORD_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mems_spi_arbiter_if.slave    bus
);

  localparam int TW = (ACCEPT_TIMEOUT > 1) ? $clog2(ACCEPT_TIMEOUT) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(ACCEPT_TIMEOUT - 1);

  if (ACCEPT_TIMEOUT < 1 || REFRESH_CYCLES < 2) begin : g_cfg_check
    $error("mems_spi_arbiter: ACCEPT_TIMEOUT must be >= 1 and REFRESH_CYCLES >= 2");
  end

  state_e            state_q;
  owner_e            owner_q;
  owner_e            winner;
  logic              start_q, scan_ack_q, host_ack_q, err_q, last_host_q;
  logic [WORD_W-1:0] data_q;
  logic [TW-1:0]     tmo_q;
  logic              refresh_pending, scan_pend, host_pend;

  // A requester still shows req during its ack cycle; that is the old request.
  assign scan_pend = bus.scan_req & ~scan_ack_q;
  assign host_pend = bus.host_req & ~host_ack_q;
  assign winner    = pick_owner(refresh_pending, scan_pend, host_pend, last_host_q);

`ifdef MEMS_ARB_REFRESH_EN
  logic grant_refresh;
  assign grant_refresh = (state_q == ST_IDLE) && !bus.hold && (winner == OWN_REFRESH);

  mems_refresh_timer #(.REFRESH_CYCLES(REFRESH_CYCLES)) u_refresh_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .grant   (grant_refresh),
    .pending (refresh_pending)
  );
`else
  assign refresh_pending = 1'b0;
`endif

  // NOTE: state uses non-blocking assignments; the defaults at the top of the
  // clocked branch are overridden by later assignments in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      owner_q     <= OWN_NONE;
      start_q     <= 1'b0;
      scan_ack_q  <= 1'b0;
      host_ack_q  <= 1'b0;
      err_q       <= 1'b0;
      last_host_q <= 1'b1;
      data_q      <= '0;
      tmo_q       <= '0;
    end else begin
      start_q    <= 1'b0;
      scan_ack_q <= 1'b0;
      host_ack_q <= 1'b0;
      if (bus.err_clr) err_q <= 1'b0;

      unique case (state_q)
        ST_IDLE: begin
          if (!bus.hold && winner != OWN_NONE) begin
            owner_q <= winner;
            start_q <= 1'b1;
            state_q <= ST_START;
            case (winner)
              OWN_SCAN: begin data_q <= bus.scan_word; last_host_q <= 1'b0; end
              OWN_HOST: begin data_q <= bus.host_word; last_host_q <= 1'b1; end
              default:  data_q <= VREF_WORD;
            endcase
          end
        end
        ST_START: begin
          tmo_q   <= '0;
          state_q <= ST_ACCEPT;
        end
        ST_ACCEPT: begin
          if (bus.mems_SPI_busy) begin
            state_q <= ST_XFER;
          end else if (tmo_q == TMO_LAST) begin
            err_q      <= 1'b1;
            scan_ack_q <= (owner_q == OWN_SCAN);
            host_ack_q <= (owner_q == OWN_HOST);
            owner_q    <= OWN_NONE;
            state_q    <= ST_IDLE;
          end else begin
            tmo_q <= tmo_q + TW'(1);
          end
        end
        ST_XFER: begin
          if (!bus.mems_SPI_busy) begin
            scan_ack_q <= (owner_q == OWN_SCAN);
            host_ack_q <= (owner_q == OWN_HOST);
            owner_q    <= OWN_NONE;
            state_q    <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.mems_SPI_start = start_q;
  assign bus.scan_ack       = scan_ack_q;
  assign bus.host_ack       = host_ack_q;
  assign bus.spi_data       = data_q;
  assign bus.owner          = owner_q;
  assign bus.err_timeout    = err_q;

endmodule

// File: tb/tb_mems_spi_arbiter.sv
// Directed self-checking bench for mems_spi_arbiter; the refresh scenario
// runs only when MEMS_ARB_REFRESH_EN is defined.
module tb_mems_spi_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  int   tests_run    = 0;
  int   tests_failed = 0;

  mems_spi_arbiter_if bus();

  mems_spi_arbiter #(
    .REFRESH_CYCLES (100),
    .ACCEPT_TIMEOUT (8),
    .VREF_WORD      (24'h700000)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.hold          = 1'b0;
    bus.scan_req      = 1'b0;
    bus.scan_word     = '0;
    bus.host_req      = 1'b0;
    bus.host_word     = '0;
    bus.mems_SPI_busy = 1'b0;
    bus.err_clr       = 1'b0;
  endtask

  task automatic reset_dut();
    clear_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic wait_start(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.mems_SPI_start === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    tests_run++;
    if ({bus.mems_SPI_start, bus.scan_ack, bus.host_ack, bus.err_timeout, bus.owner, bus.spi_data} !== 30'd0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got start=%b sack=%b hack=%b err=%b owner=%0d data=%h, expected all 0",
               bus.mems_SPI_start, bus.scan_ack, bus.host_ack, bus.err_timeout, bus.owner, bus.spi_data);
    end
    rst_n = 1'b1;
    tick();
    tick();
    tests_run++;
    if (bus.mems_SPI_start !== 1'b0 || bus.owner !== 2'd0) begin
      tests_failed++;
      $display("FAIL idle_after_reset: got start=%b owner=%0d, expected 0/0", bus.mems_SPI_start, bus.owner);
    end
  endtask

  task automatic test_single_scan();
    int ack_early = 0;
    int own_bad   = 0;
    reset_dut();
    bus.scan_word = 24'h12ABCD;
    bus.scan_req  = 1'b1;
    tick();
    tests_run++;
    if (bus.mems_SPI_start !== 1'b1) begin
      tests_failed++;
      $display("FAIL scan_start: got %b expected 1", bus.mems_SPI_start);
    end
    tests_run++;
    if (bus.spi_data !== 24'h12ABCD) begin
      tests_failed++;
      $display("FAIL scan_data: got %h expected 12abcd", bus.spi_data);
    end
    tests_run++;
    if (bus.owner !== 2'd1) begin
      tests_failed++;
      $display("FAIL scan_owner_start: got %0d expected 1", bus.owner);
    end
    tick();
    tests_run++;
    if (bus.mems_SPI_start !== 1'b0) begin
      tests_failed++;
      $display("FAIL start_width: got %b expected 0", bus.mems_SPI_start);
    end
    bus.mems_SPI_busy = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.scan_ack !== 1'b0) ack_early++;
      if (bus.owner !== 2'd1) own_bad++;
    end
    bus.mems_SPI_busy = 1'b0;
    tests_run++;
    if (ack_early != 0 || own_bad != 0) begin
      tests_failed++;
      $display("FAIL scan_during_xfer: got early_acks=%0d bad_owner=%0d expected 0/0", ack_early, own_bad);
    end
    tick();
    tests_run++;
    if (bus.scan_ack !== 1'b1 || bus.owner !== 2'd0 || bus.spi_data !== 24'h12ABCD) begin
      tests_failed++;
      $display("FAIL scan_ack: got ack=%b owner=%0d data=%h expected 1/0/12abcd", bus.scan_ack, bus.owner, bus.spi_data);
    end
    bus.scan_req = 1'b0;
    tick();
    tests_run++;
    if (bus.scan_ack !== 1'b0 || bus.mems_SPI_start !== 1'b0) begin
      tests_failed++;
      $display("FAIL scan_ack_width: got ack=%b start=%b expected 0/0", bus.scan_ack, bus.mems_SPI_start);
    end
  endtask

  task automatic test_round_robin();
    logic [1:0]  exp_owner [4] = '{2'd1, 2'd2, 2'd1, 2'd2};
    logic [23:0] exp_word;
    logic        got_ack, other_ack;
    reset_dut();
    bus.scan_word = 24'h111111;
    bus.host_word = 24'h222222;
    bus.scan_req  = 1'b1;
    bus.host_req  = 1'b1;
    tick();
    for (int k = 0; k < 4; k++) begin
      exp_word = (exp_owner[k] == 2'd1) ? 24'h111111 : 24'h222222;
      tests_run++;
      if (bus.mems_SPI_start !== 1'b1) begin
        tests_failed++;
        $display("FAIL rr_start_%0d: got %b expected 1", k, bus.mems_SPI_start);
      end
      tests_run++;
      if (bus.owner !== exp_owner[k] || bus.spi_data !== exp_word) begin
        tests_failed++;
        $display("FAIL rr_grant_%0d: got owner=%0d data=%h expected %0d/%h", k, bus.owner, bus.spi_data, exp_owner[k], exp_word);
      end
      tick();
      bus.mems_SPI_busy = 1'b1;
      tick();
      tick();
      bus.mems_SPI_busy = 1'b0;
      tick();
      got_ack   = (exp_owner[k] == 2'd1) ? bus.scan_ack : bus.host_ack;
      other_ack = (exp_owner[k] == 2'd1) ? bus.host_ack : bus.scan_ack;
      tests_run++;
      if (got_ack !== 1'b1 || other_ack !== 1'b0) begin
        tests_failed++;
        $display("FAIL rr_ack_%0d: got winner_ack=%b other_ack=%b expected 1/0", k, got_ack, other_ack);
      end
      if (k == 3) begin
        bus.scan_req = 1'b0;
        bus.host_req = 1'b0;
      end
      tick();
    end
    tests_run++;
    if (bus.mems_SPI_start !== 1'b0) begin
      tests_failed++;
      $display("FAIL rr_no_extra_start: got %b expected 0", bus.mems_SPI_start);
    end
  endtask

  task automatic test_timeout();
    int early = 0;
    reset_dut();
    bus.scan_word = 24'h0ABCDE;
    bus.scan_req  = 1'b1;
    tick();
    tick();
    for (int i = 0; i < 7; i++) begin
      tick();
      if (bus.scan_ack !== 1'b0 || bus.err_timeout !== 1'b0) early++;
    end
    tests_run++;
    if (early != 0) begin
      tests_failed++;
      $display("FAIL timeout_early: got %0d early cycles expected 0", early);
    end
    tick();
    tests_run++;
    if (bus.err_timeout !== 1'b1 || bus.scan_ack !== 1'b1 || bus.owner !== 2'd0) begin
      tests_failed++;
      $display("FAIL timeout_fire: got err=%b ack=%b owner=%0d expected 1/1/0", bus.err_timeout, bus.scan_ack, bus.owner);
    end
    bus.scan_req = 1'b0;
    tick();
    tests_run++;
    if (bus.err_timeout !== 1'b1 || bus.scan_ack !== 1'b0) begin
      tests_failed++;
      $display("FAIL timeout_sticky: got err=%b ack=%b expected 1/0", bus.err_timeout, bus.scan_ack);
    end
    bus.err_clr = 1'b1;
    tick();
    bus.err_clr = 1'b0;
    tests_run++;
    if (bus.err_timeout !== 1'b0) begin
      tests_failed++;
      $display("FAIL err_clr: got %b expected 0", bus.err_timeout);
    end
    // Clear held high across a second timeout: the set must still win.
    bus.err_clr  = 1'b1;
    bus.scan_req = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    tests_run++;
    if (bus.err_timeout !== 1'b1 || bus.scan_ack !== 1'b1) begin
      tests_failed++;
      $display("FAIL timeout_set_wins: got err=%b ack=%b expected 1/1", bus.err_timeout, bus.scan_ack);
    end
    bus.scan_req = 1'b0;
    tick();
    tests_run++;
    if (bus.err_timeout !== 1'b0) begin
      tests_failed++;
      $display("FAIL err_clr_after_set: got %b expected 0", bus.err_timeout);
    end
    bus.err_clr = 1'b0;
  endtask

  task automatic test_hold();
    int seen = 0;
    reset_dut();
    bus.hold      = 1'b1;
    bus.host_word = 24'h345678;
    bus.host_req  = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus.mems_SPI_start !== 1'b0) seen++;
    end
    tests_run++;
    if (seen != 0) begin
      tests_failed++;
      $display("FAIL hold_blocks: got %0d starts expected 0", seen);
    end
    bus.hold = 1'b0;
    tick();
    tests_run++;
    if (bus.mems_SPI_start !== 1'b1 || bus.owner !== 2'd2 || bus.spi_data !== 24'h345678) begin
      tests_failed++;
      $display("FAIL hold_release: got start=%b owner=%0d data=%h expected 1/2/345678", bus.mems_SPI_start, bus.owner, bus.spi_data);
    end
    bus.hold = 1'b1;
    tick();
    bus.mems_SPI_busy = 1'b1;
    tick();
    bus.mems_SPI_busy = 1'b0;
    tick();
    tests_run++;
    if (bus.host_ack !== 1'b1) begin
      tests_failed++;
      $display("FAIL hold_inflight_completes: got host_ack=%b expected 1", bus.host_ack);
    end
    bus.host_req = 1'b0;
    tick();
    bus.hold = 1'b0;
  endtask

  task automatic test_reset_mid_xfer();
    reset_dut();
    bus.scan_word = 24'h5A5A5A;
    bus.scan_req  = 1'b1;
    tick();
    tick();
    bus.mems_SPI_busy = 1'b1;
    tick();
    tick();
    tests_run++;
    if (bus.owner !== 2'd1) begin
      tests_failed++;
      $display("FAIL midreset_pre_owner: got %0d expected 1", bus.owner);
    end
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({bus.mems_SPI_start, bus.scan_ack, bus.host_ack, bus.err_timeout, bus.owner, bus.spi_data} !== 30'd0) begin
      tests_failed++;
      $display("FAIL midreset_outputs: got start=%b sack=%b hack=%b err=%b owner=%0d data=%h expected all 0",
               bus.mems_SPI_start, bus.scan_ack, bus.host_ack, bus.err_timeout, bus.owner, bus.spi_data);
    end
    bus.mems_SPI_busy = 1'b0;
    bus.scan_req      = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    bus.host_word = 24'h13579B;
    bus.host_req  = 1'b1;
    tick();
    tests_run++;
    if (bus.mems_SPI_start !== 1'b1 || bus.owner !== 2'd2 || bus.spi_data !== 24'h13579B) begin
      tests_failed++;
      $display("FAIL midreset_regrant: got start=%b owner=%0d data=%h expected 1/2/13579b", bus.mems_SPI_start, bus.owner, bus.spi_data);
    end
    tick();
    bus.mems_SPI_busy = 1'b1;
    tick();
    bus.mems_SPI_busy = 1'b0;
    tick();
    tests_run++;
    if (bus.host_ack !== 1'b1) begin
      tests_failed++;
      $display("FAIL midreset_ack: got host_ack=%b expected 1", bus.host_ack);
    end
    bus.host_req = 1'b0;
    tick();
  endtask

`ifdef MEMS_ARB_REFRESH_EN
  task automatic test_refresh();
    int          refresh_cnt = 0;
    int          bad_data    = 0;
    int          bad_ack     = 0;
    bit          ok;
    logic [1:0]  own;
    logic [23:0] word;
    reset_dut();
    bus.scan_word = 24'hABCDEF;
    bus.scan_req  = 1'b1;
    for (int t = 0; t < 40; t++) begin
      wait_start(ok);
      if (!ok) begin
        tests_run++;
        tests_failed++;
        $display("FAIL refresh_wait_start: got no start within 40 cycles, expected a start");
        break;
      end
      own  = bus.owner;
      word = bus.spi_data;
      if (own == 2'd3) begin
        refresh_cnt++;
        if (word !== 24'h700000) bad_data++;
      end else if (own !== 2'd1 || word !== 24'hABCDEF) begin
        bad_data++;
      end
      tick();
      bus.mems_SPI_busy = 1'b1;
      for (int i = 0; i < 3; i++) tick();
      bus.mems_SPI_busy = 1'b0;
      tick();
      if (own == 2'd3) begin
        if (bus.scan_ack !== 1'b0 || bus.host_ack !== 1'b0) bad_ack++;
      end else if (bus.scan_ack !== 1'b1) begin
        bad_ack++;
      end
    end
    bus.scan_req = 1'b0;
    tests_run++;
    if (refresh_cnt != 2) begin
      tests_failed++;
      $display("FAIL refresh_count: got %0d expected 2", refresh_cnt);
    end
    tests_run++;
    if (bad_data != 0) begin
      tests_failed++;
      $display("FAIL refresh_data: got %0d bad grants expected 0", bad_data);
    end
    tests_run++;
    if (bad_ack != 0) begin
      tests_failed++;
      $display("FAIL refresh_ack: got %0d bad acks expected 0", bad_ack);
    end
    tick();
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single_scan();
    test_round_robin();
    test_timeout();
    test_hold();
    test_reset_mid_xfer();
`ifdef MEMS_ARB_REFRESH_EN
    test_refresh();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
